uart_rx_buffer: RTL and testbench

UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

---
 rtl/uart_rx_buffer.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_buffer.sv
// UART receiver (8N1, LSB first) with an output buffer and valid/ready drain.
// Define UART_RX_FIFO_EN for a DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_buffer #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DEPTH      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic [4:0] count,
    output logic       overflow,
    output logic       framing_error
);
    localparam int BIT_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF     = BIT_TIME / 2;
    localparam int CW       = $clog2(BIT_TIME + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TIME - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_next;
    logic          sync_meta, line;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shift, shift_next;
    logic          push, ferr_next;
    logic          pop, full, push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            line      <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            line      <= sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bit_idx       <= bit_idx_next;
            shift         <= shift_next;
            framing_error <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        push         = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!line) state_next = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {line, shift[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (line) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_next = '0;
                if (line) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A push into a full buffer still lands when the head leaves on the same edge.
    assign data_out_valid = (count != '0);
    assign pop            = data_out_valid && data_out_ready;
    assign push_ok        = push && (!full || pop);

`ifdef UART_RX_FIFO_EN
    localparam int PW = $clog2(DEPTH);
    localparam logic [4:0] CAP = 5'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign full     = (count == CAP);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] hold;

    assign full     = count[0];
    assign data_out = hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) hold <= shift;
            if (push && !push_ok) overflow <= 1'b1;
            if (push_ok && !pop)      count <= 5'd1;
            else if (pop && !push_ok) count <= 5'd0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboarded bench for uart_rx_buffer: serial frames in, expected bytes queued, monitor pops and compares.
module tb_uart_rx_buffer;
    localparam int CLOCK_FREQ = 1_700_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int DEPTH      = 8;
    localparam int BT         = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF       = BT / 2;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [4:0] count;
    logic       overflow;
    logic       framing_error;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int ferr_cycles = 0;
    int valid_cycles = 0;
    int exp_ferr = 0;
    bit exp_ovf = 1'b0;
    logic [7:0] exp_q [$];

    uart_rx_buffer #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .count         (count),
        .overflow      (overflow),
        .framing_error (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       data_out_ready = 1'b0;
            1:       data_out_ready = 1'b1;
            default: data_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every accepted byte must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (int'(count) > CAP || data_out_valid != (count != 5'd0)) begin
                errors++;
                $display("FAIL occupancy: count=%0d valid=%0b, required count<=%0d and valid==(count!=0)",
                         count, data_out_valid, CAP);
            end
            if (framing_error) ferr_cycles++;
            if (data_out_valid) valid_cycles++;
            if (data_out_valid && data_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%02h, required no byte", data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        errors++;
                        $display("FAIL data_out: got 0x%02h, required 0x%02h", data_out, e);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        serial_in = 1'b0;
        tick(BT);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(BT);
        end
        serial_in = stop_bit;
        tick(BT);
        serial_in = 1'b1;
        tick(2 * BT);
    endtask

    // Reference buffer: a byte is accepted only if the buffer has room.
    task automatic expect_byte(input logic [7:0] b);
        if (exp_q.size() < CAP) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        tick(2);
    endtask

    initial begin
        int v0;
        logic [7:0] b;
        rst       = 1'b1;
        serial_in = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data_out", int'(data_out), 0);
        check("reset_valid", int'(data_out_valid), 0);
        check("reset_count", int'(count), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_framing_error", int'(framing_error), 0);
        tick(1);

        // Single byte with consumer always ready: valid for exactly one cycle.
        ready_mode = 1;
        v0 = valid_cycles;
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1);
        drain();
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_count", int'(count), 0);
        check("a5_overflow", int'(overflow), 0);

        // Start-bit glitch shorter than half a bit is rejected.
        serial_in = 1'b0;
        tick(HALF - 3);
        serial_in = 1'b1;
        tick(3 * BT);
        check("glitch_count", int'(count), 0);
        check("glitch_ferr_cycles", ferr_cycles, 0);

        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0);
        exp_ferr++;
        check("ferr_pulse_cycles", ferr_cycles, exp_ferr);
        check("ferr_count", int'(count), 0);
        expect_byte(8'h7E);
        send_frame(8'h7E, 1'b1);
        drain();

        // Random bytes, random backpressure, occasional bad stop bits.
        ready_mode = 2;
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) begin
                send_frame(b, 1'b0);
                exp_ferr++;
            end else begin
                expect_byte(b);
                send_frame(b, 1'b1);
            end
            drain();
        end
        check("random_ferr_cycles", ferr_cycles, exp_ferr);

        // Fill past capacity with no consumer.
        ready_mode = 0;
        tick(2);
        for (int i = 0; i <= CAP; i++) begin
            b = (CAP == 1) ? 8'(8'h11 * (i + 1)) : 8'(i + 1);
            expect_byte(b);
            send_frame(b, 1'b1);
        end
        @(negedge clk);
        check("full_count", int'(count), CAP);
        check("full_overflow", int'(overflow), int'(exp_ovf));
        check("full_head", int'(data_out), (CAP == 1) ? 8'h11 : 8'h01);
        tick(1);
        ready_mode = 1;
        drain();
        check("drained_count", int'(count), 0);
        check("overflow_sticky", int'(overflow), 1);

        // Reset mid-frame with a byte buffered.
        ready_mode = 0;
        tick(2);
        expect_byte(8'h99);
        send_frame(8'h99, 1'b1);
        check("pre_reset_count", int'(count), 1);
        serial_in = 1'b0;
        tick(BT);
        serial_in = 1'b1;
        tick(3 * BT);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        check("midreset_data_out", int'(data_out), 0);
        check("midreset_valid", int'(data_out_valid), 0);
        check("midreset_count", int'(count), 0);
        check("midreset_overflow", int'(overflow), 0);
        check("midreset_framing_error", int'(framing_error), 0);
        tick(1);
        ready_mode = 1;
        expect_byte(8'h5A);
        send_frame(8'h5A, 1'b1);
        drain();
        check("post_reset_count", int'(count), 0);
        check("post_reset_overflow", int'(overflow), int'(exp_ovf));
        check("total_ferr_cycles", ferr_cycles, exp_ferr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
